// File: rtl/calc_enc_chord.sv
// Push-button front end: 2-FF sync, per-button debounce, {l,c,r} -> ALU opcode encode,
// with either level-following output or chord capture issued over a valid/ready handshake.
module calc_enc_chord #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned MODE      = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btnc,
  input  logic            btnl,
  input  logic            btnr,
  input  logic            op_ready,
  output logic [OP_W-1:0] alu_op,
  output logic            op_valid,
  output logic            busy,
  output logic            drop
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

  // Button vectors are ordered {l, c, r} so they index the encode table directly.
  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] db_q, db_d;
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];

  logic [OP_W-1:0] alu_op_q;
  logic            op_valid_q;

  assign raw      = {btnl, btnc, btnr};
  assign alu_op   = alu_op_q;
  assign op_valid = op_valid_q;

  function automatic logic [3:0] enc(input logic [2:0] idx);
    logic [3:0] op;
    case (idx)
      3'b000:  op = 4'b0000;
      3'b001:  op = 4'b0001;
      3'b010:  op = 4'b0010;
      3'b011:  op = 4'b0110;
      3'b100:  op = 4'b0100;
      3'b101:  op = 4'b1001;
      3'b110:  op = 4'b1010;
      default: op = 4'b0101;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Counter runs only while the synchronised level disagrees; the edge that would reach
  // DB_CYCLES flips the debounced level instead and leaves the counter at zero.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntW'(DB_CYCLES - 1)) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  if (MODE == 0) begin : g_level
    logic unused_ready;
    assign unused_ready = op_ready;
    assign busy         = 1'b0;
    assign drop         = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        alu_op_q   <= '0;
        op_valid_q <= 1'b0;
      end else begin
        alu_op_q   <= OP_W'(enc(db_q));
        op_valid_q <= |db_q;
      end
    end
  end else begin : g_chord
    typedef enum logic {StIdle, StCollect} state_e;

    state_e     state_q;
    logic [2:0] chord_q;
    logic       busy_q;
    logic       drop_q;

    assign busy = busy_q;
    assign drop = drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= StIdle;
        chord_q    <= '0;
        busy_q     <= 1'b0;
        drop_q     <= 1'b0;
        alu_op_q   <= '0;
        op_valid_q <= 1'b0;
      end else begin
        drop_q <= 1'b0;
        // Accept retires the held opcode; a chord loading on the same edge overrides this.
        if (op_valid_q && op_ready) begin
          op_valid_q <= 1'b0;
        end
        unique case (state_q)
          StIdle: begin
            if (|db_q) begin
              chord_q <= db_q;
              state_q <= StCollect;
              busy_q  <= 1'b1;
            end
          end
          StCollect: begin
            if (db_q == 3'b000) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              if (!op_valid_q || op_ready) begin
                alu_op_q   <= OP_W'(enc(chord_q));
                op_valid_q <= 1'b1;
              end else begin
                drop_q <= 1'b1;
              end
            end else begin
              chord_q <= chord_q | db_q;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
